// File: rtl/aes256_unloading.sv
// Output-side byte collector for the AES-256 core: requests ciphertext bytes one at
// a time, packs them into a block and offers it downstream on valid/ready.
module aes256_unloading #(
  parameter int NUM_BYTES = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enc_done,
  output logic                   next_val_req,
  input  logic                   next_val_ready,
  input  logic [7:0]             data_out,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic [8*NUM_BYTES-1:0] block_data,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overrun
);

  localparam int BLK_W = 8 * NUM_BYTES;
  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  // Expiry is detected one count early so the abort lands exactly TIMEOUT cycles after WAIT entry.
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] byte_cnt_r;
  logic [CNT_W-1:0] byte_cnt_nxt_s;
  logic [9:0]       tmo_cnt_r;
  logic [9:0]       tmo_cnt_nxt_s;
  logic [BLK_W-1:0] block_nxt_s;
  logic             timeout_nxt_s;
  logic             overrun_nxt_s;

  // Next-state, counter and shift-register decode.
  always_comb begin
    state_nxt_s    = state_r;
    byte_cnt_nxt_s = byte_cnt_r;
    tmo_cnt_nxt_s  = tmo_cnt_r;
    block_nxt_s    = block_data;
    timeout_nxt_s  = 1'b0;
    overrun_nxt_s  = 1'b0;

    if (enc_done && (state_r != ST_IDLE)) begin
      overrun_nxt_s = 1'b1;
    end else begin
      overrun_nxt_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (enc_done) begin
          byte_cnt_nxt_s = '0;
          state_nxt_s    = ST_REQ;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_REQ: begin
        tmo_cnt_nxt_s = 10'd0;
        state_nxt_s   = ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving on the expiry cycle wins over the timeout.
        if (next_val_ready) begin
          block_nxt_s = BLK_W'({block_data, data_out});
          if (byte_cnt_r == LAST_BYTE) begin
            state_nxt_s = ST_OUT;
          end else begin
            byte_cnt_nxt_s = byte_cnt_r + CNT_W'(1);
            state_nxt_s    = ST_REQ;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          tmo_cnt_nxt_s = tmo_cnt_r + 10'd1;
          timeout_nxt_s = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + 10'd1;
          state_nxt_s   = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (block_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs decode from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      byte_cnt_r   <= '0;
      tmo_cnt_r    <= 10'd0;
      block_data   <= '0;
      next_val_req <= 1'b0;
      block_valid  <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      byte_cnt_r   <= byte_cnt_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      block_data   <= block_nxt_s;
      next_val_req <= (state_nxt_s == ST_REQ);
      block_valid  <= (state_nxt_s == ST_OUT);
      busy         <= (state_nxt_s != ST_IDLE);
      timeout_err  <= timeout_nxt_s;
      overrun      <= overrun_nxt_s;
    end
  end

endmodule

// File: tb/tb_aes256_unloading.sv
// Directed bench for aes256_unloading: scenario tasks drive a cycle-accurate
// responder and compare observed timing/data against hand-derived values.
module tb_aes256_unloading;

  localparam int NB = 16;
  localparam int BW = 8 * NB;

  logic          clk;
  logic          rst;
  logic          enc_done;
  logic          next_val_req;
  logic          next_val_ready;
  logic [7:0]    data_out;
  logic          block_valid;
  logic          block_ready;
  logic [BW-1:0] block_data;
  logic          busy;
  logic          timeout_err;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  // Observations of the last collect() run; cycle 0 is the enc_done cycle.
  int          req_cnt, first_req, valid_cyc, ready_cyc, end_cyc, tmo_cyc;
  int          ovr_cnt, ovr_first, unstable, busy_at1;
  logic [BW-1:0] data_cap;
  int          lat_tab [16] = '{3, 1, 7, 20, 2, 11, 5, 1, 14, 9, 4, 18, 6, 2, 13, 1};

  aes256_unloading #(.NUM_BYTES(NB), .TIMEOUT(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .enc_done       (enc_done),
    .next_val_req   (next_val_req),
    .next_val_ready (next_val_ready),
    .data_out       (data_out),
    .block_valid    (block_valid),
    .block_ready    (block_ready),
    .block_data     (block_data),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] exp_block(input logic [7:0] seed);
    logic [BW-1:0] e;
    e = '0;
    for (int k = 0; k < NB; k++) e = {e[BW-9:0], seed + 8'(k)};
    return e;
  endfunction

  // Starts a block and plays the core side until the block is handed off,
  // a timeout is seen, or max_cyc elapses. Records observations only.
  task automatic collect(input logic [7:0] seed, input int lat_sel, input int stall_idx,
                         input int stall_lat, input int ready_delay, input int ovr_c1,
                         input int ovr_c2, input int max_cyc);
    int due, k, lat;
    bit pend, done;
    logic [7:0] pbyte;
    req_cnt = 0; first_req = -1; valid_cyc = -1; ready_cyc = -1; end_cyc = -1;
    tmo_cyc = -1; ovr_cnt = 0; ovr_first = -1; unstable = 0; busy_at1 = 0;
    pend = 1'b0; done = 1'b0; due = 0; pbyte = 8'h00;
    for (int c = 0; c <= max_cyc && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1) busy_at1 = int'(busy);
        if (next_val_req) begin
          k = req_cnt;
          req_cnt++;
          if (first_req < 0) first_req = c;
          lat = (lat_sel == 1) ? lat_tab[k % NB] : 1;
          if (k == stall_idx) lat = stall_lat;
          pend = 1'b1; due = c + lat; pbyte = seed + 8'(k);
        end
        if (timeout_err && tmo_cyc < 0) tmo_cyc = c;
        if (overrun) begin
          ovr_cnt++;
          if (ovr_first < 0) ovr_first = c;
        end
        if (block_valid) begin
          if (valid_cyc < 0) begin
            valid_cyc = c; data_cap = block_data;
          end else if (block_data !== data_cap) begin
            unstable = 1;
          end
        end else if (valid_cyc >= 0) begin
          end_cyc = c; done = 1'b1;
        end
        if (tmo_cyc >= 0) done = 1'b1;
      end
      if (done) begin
        enc_done = 1'b0; next_val_ready = 1'b0; data_out = 8'h00; block_ready = 1'b0;
      end else begin
        enc_done = (c == 0) || (c == ovr_c1) || (c == ovr_c2);
        if (pend && c == due) begin
          next_val_ready = 1'b1; data_out = pbyte; pend = 1'b0;
        end else begin
          next_val_ready = 1'b0; data_out = 8'h00;
        end
        block_ready = block_valid && (c >= valid_cyc + ready_delay);
        if (block_ready && ready_cyc < 0) ready_cyc = c;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; enc_done = 1'b0; next_val_ready = 1'b0; data_out = 8'h00; block_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({next_val_req, block_valid, busy, timeout_err, overrun} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {next_val_req, block_valid, busy, timeout_err, overrun});
    end
    checks++; if (block_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", block_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal;
    collect(8'h00, 0, -1, 0, 0, -1, -1, 200);
    checks++; if (first_req !== 1) begin errors++; $display("FAIL nom_first_req: got %0d expected 1", first_req); end
    checks++; if (busy_at1 !== 1) begin errors++; $display("FAIL nom_busy: got %0d expected 1", busy_at1); end
    checks++; if (req_cnt !== 16) begin errors++; $display("FAIL nom_req_cnt: got %0d expected 16", req_cnt); end
    checks++; if (valid_cyc !== 33) begin errors++; $display("FAIL nom_valid_cyc: got %0d expected 33", valid_cyc); end
    checks++; if (data_cap !== 128'h000102030405060708090A0B0C0D0E0F) begin
      errors++; $display("FAIL nom_data: got %h expected 000102030405060708090a0b0c0d0e0f", data_cap);
    end
    checks++; if (end_cyc !== 34) begin errors++; $display("FAIL nom_valid_drop: got %0d expected 34", end_cyc); end
    checks++; if (tmo_cyc !== -1 || ovr_cnt !== 0) begin
      errors++; $display("FAIL nom_no_err: got tmo=%0d ovr=%0d expected -1 0", tmo_cyc, ovr_cnt);
    end
  endtask

  task automatic test_back_to_back;
    collect(8'h30, 0, -1, 0, 0, -1, -1, 200);
    checks++; if (first_req !== 1) begin errors++; $display("FAIL b2b_first_req: got %0d expected 1", first_req); end
    checks++; if (data_cap !== exp_block(8'h30)) begin
      errors++; $display("FAIL b2b_data: got %h expected %h", data_cap, exp_block(8'h30));
    end
  endtask

  task automatic test_latency_backpressure;
    collect(8'h5A, 1, -1, 0, 10, -1, -1, 500);
    checks++; if (valid_cyc !== 134) begin errors++; $display("FAIL lat_valid_cyc: got %0d expected 134", valid_cyc); end
    checks++; if (data_cap !== exp_block(8'h5A)) begin
      errors++; $display("FAIL lat_data: got %h expected %h", data_cap, exp_block(8'h5A));
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL lat_stable: got %0d expected 0", unstable); end
    checks++; if (ready_cyc !== 144) begin errors++; $display("FAIL lat_ready_cyc: got %0d expected 144", ready_cyc); end
    checks++; if (end_cyc !== 145) begin errors++; $display("FAIL lat_valid_drop: got %0d expected 145", end_cyc); end
  endtask

  task automatic test_timeout;
    collect(8'h20, 0, 3, 100000, 0, -1, -1, 300);
    checks++; if (tmo_cyc !== 72) begin errors++; $display("FAIL tmo_cyc: got %0d expected 72", tmo_cyc); end
    checks++; if (valid_cyc !== -1) begin errors++; $display("FAIL tmo_no_valid: got %0d expected -1", valid_cyc); end
    checks++; if (req_cnt !== 4) begin errors++; $display("FAIL tmo_req_cnt: got %0d expected 4", req_cnt); end
    // Next block starts in the very cycle that carries the timeout pulse.
    collect(8'h40, 0, -1, 0, 0, -1, -1, 200);
    checks++; if (first_req !== 1) begin errors++; $display("FAIL tmo_next_req: got %0d expected 1", first_req); end
    checks++; if (tmo_cyc !== -1) begin errors++; $display("FAIL tmo_pulse_len: got %0d expected -1", tmo_cyc); end
    checks++; if (data_cap !== exp_block(8'h40)) begin
      errors++; $display("FAIL tmo_next_data: got %h expected %h", data_cap, exp_block(8'h40));
    end
  endtask

  task automatic test_timeout_boundary;
    collect(8'h80, 0, 3, 64, 0, -1, -1, 300);
    checks++; if (tmo_cyc !== -1) begin errors++; $display("FAIL bnd_no_tmo: got %0d expected -1", tmo_cyc); end
    checks++; if (valid_cyc !== 96) begin errors++; $display("FAIL bnd_valid_cyc: got %0d expected 96", valid_cyc); end
    checks++; if (data_cap !== exp_block(8'h80)) begin
      errors++; $display("FAIL bnd_data: got %h expected %h", data_cap, exp_block(8'h80));
    end
  endtask

  task automatic test_overrun;
    collect(8'hA0, 0, -1, 0, 3, 6, 34, 200);
    checks++; if (ovr_cnt !== 2) begin errors++; $display("FAIL ovr_cnt: got %0d expected 2", ovr_cnt); end
    checks++; if (ovr_first !== 7) begin errors++; $display("FAIL ovr_first: got %0d expected 7", ovr_first); end
    checks++; if (req_cnt !== 16) begin errors++; $display("FAIL ovr_req_cnt: got %0d expected 16", req_cnt); end
    checks++; if (valid_cyc !== 33 || end_cyc !== 37) begin
      errors++; $display("FAIL ovr_timing: got valid=%0d drop=%0d expected 33 37", valid_cyc, end_cyc);
    end
    checks++; if (data_cap !== exp_block(8'hA0)) begin
      errors++; $display("FAIL ovr_data: got %h expected %h", data_cap, exp_block(8'hA0));
    end
  endtask

  task automatic test_reset_mid;
    int seen_valid, seen_tmo, seen_busy;
    collect(8'h10, 0, 5, 100000, 0, -1, -1, 12);
    checks++; if (busy !== 1'b1 || block_data[39:0] !== 40'h1011121314) begin
      errors++; $display("FAIL mid_pre: got busy=%b data=%h expected 1 ..1011121314", busy, block_data[39:0]);
    end
    rst = 1'b0;
    #1;
    checks++; if ({next_val_req, block_valid, busy, timeout_err, overrun} !== 5'b00000) begin
      errors++; $display("FAIL mid_reset_ctrl: got %b expected 00000", {next_val_req, block_valid, busy, timeout_err, overrun});
    end
    checks++; if (block_data !== '0) begin
      errors++; $display("FAIL mid_reset_data: got %h expected 0", block_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    seen_valid = 0; seen_tmo = 0; seen_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (block_valid) seen_valid++;
      if (timeout_err) seen_tmo++;
      if (busy) seen_busy++;
    end
    checks++; if (seen_valid !== 0 || seen_tmo !== 0 || seen_busy !== 0) begin
      errors++; $display("FAIL mid_after: got valid=%0d tmo=%0d busy=%0d expected 0 0 0", seen_valid, seen_tmo, seen_busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_latency_backpressure();
    test_timeout();
    test_timeout_boundary();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
